// File: rtl/icache_nway_pkg.sv
// Shared definitions for the N-way instruction cache: FSM encoding and
// address-split widths derived from the cache geometry.
package icache_nway_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        REFILL,
        INVAL
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int line_words, input int sets);
        return addr_w - calc_off_w(line_words) - calc_idx_w(sets);
    endfunction

    // A single-way cache still carries a one-bit way number.
    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: tag RAM plus LINE_WORDS word banks, all with registered
// (one-cycle) reads and independent per-bank write enables.
module icache_way_array #(
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 20,
    parameter int IDX_W      = 7
) (
    input  logic                        clk,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [LINE_WORDS-1:0][31:0] rd_data,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic                        tag_we,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [LINE_WORDS-1:0]       data_we,
    input  logic [31:0]                 wr_data
);

    logic [TAG_W-1:0] tag_mem [SETS];

    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[wr_idx] <= wr_tag;
        rd_tag <= tag_mem[rd_idx];
    end

    for (genvar b = 0; b < LINE_WORDS; b++) begin : g_bank
        logic [31:0] mem [SETS];
        logic [31:0] rd_q;

        always_ff @(posedge clk) begin
            if (data_we[b]) mem[wr_idx] <= wr_data;
            rd_q <= mem[rd_idx];
        end

        assign rd_data[b] = rd_q;
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative blocking I-cache with early restart, flush-safe refill
// and invalidate sweep. Define ICACHE_STATS_EN to add hit/miss counters.
module icache_nway
    import icache_nway_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_ena,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    input  logic              flush,
    input  logic              inv_req,
    output logic              inv_busy,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic              m_rready
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W  = calc_off_w(LINE_WORDS);
    localparam int IDX_W  = calc_idx_w(SETS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_WORDS, SETS);
    localparam int WAY_W  = calc_way_w(WAYS);
    localparam int WORD_W = OFF_W - 2;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              ena_q, cancel_q, rv_q, inv_pend_q;
    logic [31:0]       rdata_q;
    logic [WAY_W-1:0]  victim_q, victim_c;
    logic [WORD_W-1:0] cnt_q;
    logic [IDX_W-1:0]  sweep_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  ptr_q [SETS];

    logic [TAG_W-1:0]            way_tag  [WAYS];
    logic [LINE_WORDS-1:0][31:0] way_data [WAYS];

    logic [IDX_W-1:0]  idx_q, rd_idx;
    logic [TAG_W-1:0]  tag_q;
    logic [WORD_W-1:0] word_q;
    logic [WAYS-1:0]   set_valid;
    logic              accept, beat, req_beat, line_done, hit;
    logic [31:0]       hit_word;

    assign idx_q     = addr_q[OFF_W +: IDX_W];
    assign tag_q     = addr_q[ADDR_W-1 -: TAG_W];
    assign word_q    = addr_q[2 +: WORD_W];
    // Arrays are addressed from the incoming request so the read lands in LOOKUP.
    assign rd_idx    = (state_q == IDLE) ? s_araddr[OFF_W +: IDX_W] : idx_q;
    assign set_valid = valid_q[idx_q];

    assign s_arready = (state_q == IDLE) && !flush && !inv_pend_q && !rst;
    assign accept    = s_arvalid && s_arready;
    assign beat      = (state_q == REFILL) && m_rvalid;
    assign req_beat  = beat && (!ena_q || cnt_q == word_q);
    assign line_done = beat && m_rlast && ena_q && !cancel_q && !flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_WORDS-1:0] data_we;

        always_comb begin
            data_we = '0;
            if (beat && ena_q && victim_q == WAY_W'(w)) data_we[cnt_q] = 1'b1;
        end

        icache_way_array #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W),
            .IDX_W      (IDX_W)
        ) u_way (
            .clk     (clk),
            .rd_idx  (rd_idx),
            .rd_tag  (way_tag[w]),
            .rd_data (way_data[w]),
            .wr_idx  (idx_q),
            .tag_we  (line_done && victim_q == WAY_W'(w)),
            .wr_tag  (tag_q),
            .data_we (data_we),
            .wr_data (m_rdata)
        );
    end

    // Victim search runs high-to-low so the lowest invalid way wins.
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        victim_c = ptr_q[idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim_c = WAY_W'(w);
            if (set_valid[w] && way_tag[w] == tag_q) begin
                hit      = 1'b1;
                hit_word = way_data[w][word_q];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (inv_pend_q)  state_n = INVAL;
                else if (accept) state_n = cache_ena ? LOOKUP : MISS_AR;
            end
            LOOKUP:  state_n = (hit || flush) ? IDLE : MISS_AR;
            MISS_AR: if (m_arready) state_n = REFILL;
            REFILL:  if (beat && m_rlast) state_n = IDLE;
            INVAL:   if (!inv_req && sweep_q == IDX_W'(SETS - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign s_rvalid  = ((state_q == LOOKUP) && hit && !flush) || (rv_q && !flush);
    assign s_rdata   = (state_q == LOOKUP) ? hit_word : rdata_q;
    assign m_arvalid = (state_q == MISS_AR);
    assign m_araddr  = ena_q ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : addr_q;
    assign m_arlen   = ena_q ? 8'(LINE_WORDS - 1) : 8'd0;
    assign m_rready  = 1'b1;
    assign inv_busy  = inv_pend_q || (state_q == INVAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ena_q      <= 1'b0;
            cancel_q   <= 1'b0;
            rv_q       <= 1'b0;
            rdata_q    <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            sweep_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_n;
            rv_q    <= req_beat && !cancel_q && !flush;
            if (req_beat) rdata_q <= m_rdata;
            if (accept) begin
                addr_q   <= s_araddr;
                ena_q    <= cache_ena;
                cancel_q <= 1'b0;
            end
            if ((state_q == MISS_AR || state_q == REFILL) && flush) cancel_q <= 1'b1;
            // The victim is invalidated up front so a cancelled refill leaves no stale line.
            if (state_q == LOOKUP && !hit && !flush) begin
                victim_q                   <= victim_c;
                valid_q[idx_q][victim_c]   <= 1'b0;
            end
            if (state_q == MISS_AR) cnt_q <= '0;
            else if (beat)          cnt_q <= cnt_q + 1'b1;
            if (line_done) begin
                valid_q[idx_q][victim_q] <= 1'b1;
                if (victim_q == ptr_q[idx_q]) ptr_q[idx_q] <= ptr_q[idx_q] + WAY_W'(WAYS > 1);
            end
            if (state_q == IDLE && inv_pend_q)  inv_pend_q <= 1'b0;
            else if (inv_req && state_q != INVAL) inv_pend_q <= 1'b1;
            if (state_q == IDLE && inv_pend_q) begin
                sweep_q <= '0;
            end else if (state_q == INVAL) begin
                valid_q[sweep_q] <= '0;
                ptr_q[sweep_q]   <= '0;
                sweep_q          <= inv_req ? '0 : sweep_q + 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == LOOKUP && !flush) begin
            if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 1'b1;
            else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: a bus-side memory model driven from tasks, with
// expected fetch data queued at request time and compared on s_rvalid.
module tb_icache_nway;

  localparam int SETS = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ena;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        flush;
  logic        inv_req;
  logic        inv_busy;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_nway #(.WAYS(2), .SETS(SETS), .LINE_WORDS(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .flush(flush),
    .inv_req(inv_req), .inv_busy(inv_busy),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ar_cnt = 0;
  int rv_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && m_arvalid && m_arready) ar_cnt++;
    if (!rst && s_rvalid) begin
      rv_cnt++;
      if (exp_q.size() == 0) check("rv_unexpected", 32'(exp_q.size()), 32'd1);
      else check("rdata", s_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // flush_at: -1 none, 0..7 flush on that refill beat, 100 flush while AR pending
  task automatic do_read(input logic [31:0] addr, input logic ena, input logic exp_miss, input int flush_at);
    int ar0, rv0, n, beats, req, d;
    logic [31:0] base;
    ar0   = ar_cnt;
    rv0   = rv_cnt;
    base  = ena ? {addr[31:5], 5'b0} : addr;
    beats = ena ? 8 : 1;
    req   = ena ? int'(addr[4:2]) : 0;
    if (flush_at < 0) exp_q.push_back(mem_word(addr));
    s_araddr  = addr;
    cache_ena = ena;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (!exp_miss) begin
      check("hit_latency", 32'(s_rvalid), 32'd1);
      @(posedge clk); #1;
    end else begin
      n = 0;
      while (!m_arvalid && n < 20) begin @(posedge clk); #1; n++; end
      check("ar_wait", 32'(n < 20), 32'd1);
      if (flush_at == 100) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("ar_hold_flush", 32'(m_arvalid), 32'd1);
      end
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(posedge clk); #1;
        check("ar_hold", 32'(m_arvalid), 32'd1);
      end
      m_arready = 1'b1;
      check("araddr", m_araddr, base);
      check("arlen", 32'(m_arlen), 32'(beats - 1));
      @(posedge clk); #1;
      m_arready = 1'b0;
      for (int b = 0; b < beats; b++) begin
        m_rvalid = 1'b1;
        m_rdata  = mem_word(base + 32'(4 * b));
        m_rlast  = (b == beats - 1);
        flush    = (b == flush_at);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        flush    = 1'b0;
        check("early_restart", 32'(s_rvalid), 32'(b == req && flush_at < 0));
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    check("ar_count", 32'(ar_cnt - ar0), 32'(exp_miss));
    check("rv_count", 32'(rv_cnt - rv0), 32'(flush_at < 0));
  endtask

  task automatic inval_sweep(input int restart_at, input int exp_len);
    int busy, bad, n;
    inv_req = 1'b1;
    @(posedge clk); #1;
    inv_req = 1'b0;
    check("inv_busy_rise", 32'(inv_busy), 32'd1);
    busy = 0; bad = 0; n = 0;
    while (inv_busy && n < 1000) begin
      busy++;
      if (s_arready) bad++;
      inv_req = (busy == restart_at);
      @(posedge clk); #1;
      n++;
    end
    inv_req = 1'b0;
    check("inv_busy_len", 32'(busy), 32'(exp_len));
    check("inv_arready", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cache_ena = 1'b0; s_araddr = '0; s_arvalid = 1'b0;
    flush = 1'b0; inv_req = 1'b0; m_arready = 1'b0; m_rdata = '0;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(s_arready), 32'd0);
    check("rst_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_inv_busy", 32'(inv_busy), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_arready", 32'(s_arready), 32'd1);
    check("rready_const", 32'(m_rready), 32'd1);
    @(posedge clk); #1;

    // cold miss with early restart on word 2, then hit on word 5
    do_read(32'h0000_1008, 1'b1, 1'b1, -1);
    do_read(32'h0000_1014, 1'b1, 1'b0, -1);

    // three tags into index 0 of a 2-way cache: the third evicts way 0
    do_read(32'h0000_2000, 1'b1, 1'b1, -1);
    do_read(32'h0000_3000, 1'b1, 1'b1, -1);
    do_read(32'h0000_2000, 1'b1, 1'b0, -1);
    do_read(32'h0000_1000, 1'b1, 1'b1, -1);

    // uncached single beat, then the same line cached misses and fills
    do_read(32'hBFC0_0004, 1'b0, 1'b1, -1);
    do_read(32'hBFC0_0004, 1'b1, 1'b1, -1);
    do_read(32'hBFC0_0010, 1'b1, 1'b0, -1);

    // flush during refill and during the pending AR
    do_read(32'h0000_4038, 1'b1, 1'b1, 1);
    do_read(32'h0000_4038, 1'b1, 1'b1, -1);
    do_read(32'h0000_5044, 1'b1, 1'b1, 100);
    do_read(32'h0000_5044, 1'b1, 1'b1, -1);

    // random words over distinct sets: first pass misses, second hits
    for (int i = 0; i < 6; i++)
      do_read(32'h0000_9100 + 32'(i * 32) + 32'(4 * $urandom_range(0, 7)), 1'b1, 1'b1, -1);
    for (int i = 0; i < 6; i++)
      do_read(32'h0000_9100 + 32'(i * 32) + 32'(4 * $urandom_range(0, 7)), 1'b1, 1'b0, -1);

    // full sweep: one entry cycle plus one cycle per set
    inval_sweep(-1, SETS + 1);
    do_read(32'h0000_9104, 1'b1, 1'b1, -1);
    do_read(32'h0000_2000, 1'b1, 1'b1, -1);
    do_read(32'h0000_1000, 1'b1, 1'b1, -1);
    do_read(32'h0000_1000, 1'b1, 1'b0, -1);

    // restart on the 21st busy cycle (sweep index 19) runs all sets again
    inval_sweep(21, 21 + SETS);
    do_read(32'h0000_1000, 1'b1, 1'b1, -1);

    // async reset in the middle of a refill
    s_araddr = 32'h0000_9214; cache_ena = 1'b1; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    while (!m_arvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("rstr_ar_wait", 32'(n < 20), 32'd1);
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_word(32'h0000_9200 + 32'(4 * b));
      @(posedge clk); #1;
    end
    m_rdata = mem_word(32'h0000_920C);
    rst = 1'b1;
    #1;
    check("rstr_rvalid", 32'(s_rvalid), 32'd0);
    check("rstr_rdata", s_rdata, 32'd0);
    check("rstr_arvalid", 32'(m_arvalid), 32'd0);
    check("rstr_arready", 32'(s_arready), 32'd0);
    check("rstr_inv_busy", 32'(inv_busy), 32'd0);
    m_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h0000_9214, 1'b1, 1'b1, -1);
    do_read(32'h0000_1000, 1'b1, 1'b1, -1);
    do_read(32'h0000_9104, 1'b1, 1'b1, -1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
